// File: rtl/score_pkg.sv
// Shared types and point table for the score award path.
package score_pkg;

    typedef enum logic [1:0] {
        LARGE  = 2'd0,
        MEDIUM = 2'd1,
        SMALL  = 2'd2,
        SAUCER = 2'd3
    } hit_kind_t;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [2:0] bcd_pts_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } award_state_t;

    localparam int N_KINDS = 4;

    // Indexed by hit_kind_t; low three BCD digits of the award.
    localparam bcd_pts_t KIND_POINTS [N_KINDS] = '{12'h020, 12'h050, 12'h100, 12'h200};

endpackage

// File: rtl/hit_counter.sv
// Saturating pending-hit counter: adds a per-cycle popcount, subtracts one award.
// o_ovf pulses in any cycle where saturation discards hits.
module hit_counter #(
    parameter int CNT_W = 6,
    parameter int INC_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic [INC_W-1:0] i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_V = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_next;

    // i_dec is only asserted for a nonzero count, so this never wraps below zero.
    assign w_next = SUM_W'(r_cnt) + SUM_W'(i_inc) - SUM_W'(i_dec);
    assign o_ovf  = !i_clear && (w_next > MAX_V);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (o_ovf) begin
            r_cnt <= MAX_V[CNT_W-1:0];
        end else begin
            r_cnt <= w_next[CNT_W-1:0];
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/score_award_queue.sv
// Buffers per-kind hit counts and issues one BCD award at a time on sum, then GAP idle cycles.
// Hit-to-sum latency is two edges when idle; sum is registered and zero outside ISSUE.
module score_award_queue
    import score_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int N_SRC  = 4,
    parameter int CNT_W  = 6,
    parameter int GAP    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        hit_valid,
    input  logic [N_SRC-1:0][1:0]   hit_kind,
    input  logic                    clear,
    output logic [DIGITS-1:0][3:0]  sum,
    output logic                    busy,
    output logic                    overflow
);

    localparam int INC_W = $clog2(N_SRC + 1);
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [N_KINDS-1:0][INC_W-1:0] w_inc;
    logic [N_KINDS-1:0][CNT_W-1:0] w_cnt;
    logic [N_KINDS-1:0]            w_nz;
    logic [N_KINDS-1:0]            w_dec;
    logic [N_KINDS-1:0]            w_ovf;
    hit_kind_t                     w_sel;
    logic                          w_award;
    award_state_t                  r_state;
    award_state_t                  w_state_nxt;
    logic [3:0]                    r_gap;
    logic [3:0]                    w_gap_nxt;
    logic [DIGITS-1:0][3:0]        r_sum;
    logic [DIGITS-1:0][3:0]        w_sum_nxt;
    logic                          r_overflow;

    always_comb begin
        w_inc = '0;
        for (int k = 0; k < N_KINDS; k++) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (hit_valid[s] && (hit_kind[s] == 2'(k))) begin
                    w_inc[k] = w_inc[k] + INC_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < N_KINDS; k++) begin : g_cnt
        hit_counter #(
            .CNT_W (CNT_W),
            .INC_W (INC_W)
        ) u_cnt (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_clear (clear),
            .i_inc   (w_inc[k]),
            .i_dec   (w_dec[k]),
            .o_cnt   (w_cnt[k]),
            .o_ovf   (w_ovf[k])
        );
        assign w_nz[k] = |w_cnt[k];
    end

    // Ascending scan: the highest nonzero kind is the last one written.
    always_comb begin
        w_sel = LARGE;
        for (int k = 0; k < N_KINDS; k++) begin
            if (w_nz[k]) begin
                w_sel = hit_kind_t'(2'(k));
            end
        end
    end

    // The final WAIT cycle doubles as an idle decision point, giving GAP+1 award spacing.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_gap_nxt   = '0;
        w_sum_nxt   = '0;
        w_dec       = '0;
        w_award     = 1'b0;
        case (r_state)
            S_IDLE:  w_award = |w_nz;
            S_ISSUE: w_award = (GAP == 0) && (|w_nz);
            S_WAIT:  w_award = (r_gap == 4'd0) && (|w_nz);
            default: w_award = 1'b0;
        endcase
        if (w_award) begin
            w_state_nxt    = S_ISSUE;
            w_dec[w_sel]   = 1'b1;
            w_sum_nxt[2:0] = KIND_POINTS[w_sel];
        end else if ((r_state == S_ISSUE) && (GAP > 0)) begin
            w_state_nxt = S_WAIT;
            w_gap_nxt   = GAP_LOAD;
        end else if ((r_state == S_WAIT) && (r_gap != 4'd0)) begin
            w_state_nxt = S_WAIT;
            w_gap_nxt   = r_gap - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gap      <= '0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_gap      <= '0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap      <= w_gap_nxt;
            r_sum      <= w_sum_nxt;
            r_overflow <= r_overflow | (|w_ovf);
        end
    end

    assign sum      = r_sum;
    assign busy     = (|w_nz) || (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule
